// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//
// Registered execute stage that sits directly after alu_control. It takes the
// 4-bit ALUControl code and two operands, computes the ALU result and the zero
// flag, and presents them on a valid/ready output. The latency is one cycle and
// the stage accepts one op per cycle. A two-entry store (OUT + SKID) absorbs
// backpressure, so in_ready never depends combinationally on out_ready.
//
// Optional feature macro: ALU_EXT_OPS_EN
//   When defined, the stage also supports XOR, SLL, SRL, SRA, SLT and SLTU.
//   When undefined, those codes are handled like any other unsupported code.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clock edge where valid & ready are both 1.
//   The producer may change or drop its payload in any cycle without a
//   transfer; this block does not require inputs to be held. While out_valid
//   is 1 and out_ready is 0, result/zero/op_err remain stable.
//
// Parameters:
//   XLEN        operand/result width (default 64)
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    operands + ALUControl are valid this cycle
//   in_ready    stage can accept (registered: low only when both entries full)
//   ALUControl  op code from alu_control
//   op_a        operand A (rs1)
//   op_b        operand B (rs2 or sign-extended immediate)
//   out_valid   result/zero/op_err are valid
//   out_ready   consumer accepts the output
//   result      ALU result
//   zero        result == 0, captured together with the result
//   op_err      ALUControl code is unsupported in this build
//   fsm_state   debug view of the occupancy state (0 EMPTY, 1 ONE, 2 FULL)
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            op_err,
    output logic [1:0]      fsm_state
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e state;
    occ_e state_next;

    // OUT entry drives the outputs directly; SKID holds the next op in line.
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_err;
    logic [XLEN-1:0] skid_result;
    logic            skid_zero;
    logic            skid_err;

    // Combinational ALU on the incoming operands.
    logic [XLEN-1:0] calc_result;
    logic            calc_zero;
    logic            calc_err;

    logic accept;
    logic drain;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid_in;

    // in_ready is a pure decode of the registered state.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    assign result    = out_result;
    assign zero      = out_zero;
    assign op_err    = out_err;
    assign fsm_state = state;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        calc_result = '0;
        calc_err    = 1'b0;
        case (ALUControl)
            4'b0000: calc_result = op_a + op_b;
            4'b1000: calc_result = op_a - op_b;
            4'b0111: calc_result = op_a & op_b;
            4'b0110: calc_result = op_a | op_b;
`ifdef ALU_EXT_OPS_EN
            4'b0100: calc_result = op_a ^ op_b;
            4'b0001: calc_result = op_a << op_b[SHW-1:0];
            4'b0101: calc_result = op_a >> op_b[SHW-1:0];
            4'b1101: calc_result = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
            4'b0010: calc_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b0011: calc_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`endif
            default: begin
                // Unsupported codes still transfer normally, flagged by op_err.
                calc_result = '0;
                calc_err    = 1'b1;
            end
        endcase
    end

    // Zero is derived from the XLEN-bit result at capture time and stored.
    assign calc_zero = (calc_result == '0);

`ifndef ALU_EXT_OPS_EN
    // The shift-amount width is only consumed by the extended ops.
    logic unused_shw;
    assign unused_shw = (SHW == 0);
`endif

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid_in  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_out_in = 1'b1;
                    state_next  = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    load_skid_in = 1'b1;
                    state_next   = FULL;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // accept is impossible here because in_ready is low.
                if (drain) begin
                    load_out_skid = 1'b1;
                    state_next    = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_result <= '0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else if (load_out_in) begin
            out_result <= calc_result;
            out_zero   <= calc_zero;
            out_err    <= calc_err;
        end else if (load_out_skid) begin
            out_result <= skid_result;
            out_zero   <= skid_zero;
            out_err    <= skid_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_result <= '0;
            skid_zero   <= 1'b0;
            skid_err    <= 1'b0;
        end else if (load_skid_in) begin
            skid_result <= calc_result;
            skid_zero   <= calc_zero;
            skid_err    <= calc_err;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Directed test of alu_exec_stage. A driver task issues ops and pushes the
// hand-computed response into exp_q when the op is accepted; an independent
// monitor pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam int XLEN = 64;
    localparam int EW   = XLEN + 2;   // {op_err, zero, result}

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            op_err;
    logic [1:0]      fsm_state;

    logic [EW-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    alu_exec_stage #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (alu_control),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .op_err     (op_err),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one op starting at posedge+1; returns at posedge+1 after acceptance
    // with in_valid still high. waits = cycles spent with in_ready low.
    task automatic send(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] r, input logic z, input logic e, output int waits);
        bit done;
        alu_control = c;
        op_a        = a;
        op_b        = b;
        in_valid    = 1'b1;
        waits       = 0;
        done        = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({e, z, r});
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", waits);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no output", {op_err, zero, result});
            end else begin
                check("output", {op_err, zero, result}, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int cnt;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        alu_control = 4'b0000;
        op_a        = '0;
        op_b        = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", EW'(out_valid), EW'(1'b0));
        check("reset_outputs", {op_err, zero, result}, '0);
        check("reset_in_ready", EW'(in_ready), EW'(1'b1));
        @(posedge clk);
        #1;

        // ADD with one-cycle latency
        send(4'b0000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, w);
        check("add_latency_valid", EW'(out_valid), EW'(1'b1));
        idle(2);

        // SUB equal and SUB underflow
        send(4'b1000, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, w);
        send(4'b1000, 64'd0, 64'd1, ONES, 1'b0, 1'b0, w);
        idle(1);

        // AND / OR back-to-back, one per cycle
        send(4'b0111, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, w);
        check("and_no_wait", EW'(w), EW'(0));
        send(4'b0110, 64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, 1'b0, w);
        check("or_no_wait", EW'(w), EW'(0));
        idle(1);

        // ADD wraparound, carry dropped
        send(4'b0000, ONES, 64'd1, 64'd0, 1'b1, 1'b0, w);
        // unsupported code
        send(4'b1111, 64'd9, 64'd3, 64'd0, 1'b1, 1'b1, w);
`ifdef ALU_EXT_OPS_EN
        send(4'b0010, ONES, 64'd0, 64'd1, 1'b0, 1'b0, w);
        send(4'b0011, ONES, 64'd0, 64'd0, 1'b1, 1'b0, w);
        send(4'b0100, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, w);
        send(4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0, w);
        send(4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 1'b0, w);
        send(4'b0001, 64'd1, 64'd65, 64'd2, 1'b0, 1'b0, w);
`else
        send(4'b0010, ONES, 64'd0, 64'd0, 1'b1, 1'b1, w);
        send(4'b0100, 64'hFF, 64'h0F, 64'd0, 1'b1, 1'b1, w);
        send(4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b1, 1'b1, w);
`endif
        idle(2);

        // Backpressure: two accepted, third held off until first drains
        out_ready = 1'b0;
        send(4'b0000, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0, w);
        send(4'b1000, 64'd50, 64'd8, 64'd42, 1'b0, 1'b0, w);
        check("bp_in_ready_low", EW'(in_ready), EW'(1'b0));
        alu_control = 4'b0110;
        op_a        = 64'h100;
        op_b        = 64'h001;
        in_valid    = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_ready", EW'(in_ready), EW'(1'b0));
            check("bp_hold_output", {out_valid, op_err, zero, result}, {1'b1, 1'b0, 1'b0, 64'd30});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'b0110, 64'h100, 64'h001, 64'h101, 1'b0, 1'b0, w);
        check("bp_third_wait", EW'(w), EW'(1));
        idle(4);
        check("bp_all_drained", EW'(exp_q.size()), EW'(0));

        // Reset while FULL
        out_ready = 1'b0;
        send(4'b0000, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, w);
        send(4'b0000, 64'd2, 64'd2, 64'd4, 1'b0, 1'b0, w);
        check("full_in_ready_low", EW'(in_ready), EW'(1'b0));
        in_valid = 1'b0;
        reset    = 1'b1;
        exp_q.delete();
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", EW'(out_valid), EW'(1'b0));
        check("rst_mid_outputs", {op_err, zero, result}, '0);
        check("rst_mid_in_ready", EW'(in_ready), EW'(1'b1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'b0000, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, w);
        idle(1);

        // final drain, bounded
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            @(posedge clk);
            cnt++;
        end
        repeat (2) @(posedge clk);
        check("final_queue_empty", EW'(exp_q.size()), EW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
